// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types and default widths for the sequential ALU blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_W     = 64;
    localparam int ALU_CHUNK = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/chunk_adder.sv
`default_nettype none
// ============================================================================
// Module      : chunk_adder
// Description : Combinational w-bit slice adder with carry in and carry out.
// Revision    : 1.0 - initial release
// ============================================================================
module chunk_adder #(
    parameter int w = 8
) (
    input  logic [w-1:0] a,
    input  logic [w-1:0] b,
    input  logic         cin,
    output logic [w-1:0] s,
    output logic         cout
);

    logic [w:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b} + {{w{1'b0}}, cin};
    assign s      = w_full[w-1:0];
    assign cout   = w_full[w];

endmodule : chunk_adder
`default_nettype wire

// File: rtl/not_wordgate.sv
`default_nettype none
// ============================================================================
// Module      : not_wordgate
// Description : Bitwise inversion of a w-bit word.
// Revision    : 1.0 - initial release
// ============================================================================
module not_wordgate #(
    parameter int w = 64
) (
    input  logic [w-1:0] a,
    output logic [w-1:0] y
);

    assign y = ~a;

endmodule : not_wordgate
`default_nettype wire

// File: rtl/addsub_seq_64.sv
`default_nettype none
// ============================================================================
// Module      : addsub_seq_64
// Description : Multi-cycle W-bit adder/subtractor, CHUNK bits per clock,
//               with carry/overflow/zero flags and start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_seq_64
    import alu_pkg::*;
#(
    parameter int W     = ALU_W,
    parameter int CHUNK = ALU_CHUNK
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         op_sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);

    localparam int NCH   = W / CHUNK;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NCH - 1);

    state_t            state_q,  state_d;
    logic [IDX_W-1:0]  idx_q,    idx_d;
    logic              carry_q,  carry_d;
    logic [W-1:0]      a_q,      a_d;
    logic [W-1:0]      b_q,      b_d;
    logic [W-1:0]      result_q, result_d;
    logic              cout_q,   cout_d;
    logic              ovf_q,    ovf_d;
    logic              zero_q,   zero_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;

    logic [W-1:0]      w_b_inv;
    logic [W-1:0]      w_b_sel;
    logic [CHUNK-1:0]  w_a_slice;
    logic [CHUNK-1:0]  w_b_slice;
    logic [CHUNK-1:0]  w_sum_slice;
    logic              w_slice_cout;
    logic [W-1:0]      w_result_upd;
    logic              w_last;

    // Subtraction is A + ~B + 1: invert B here, carry-in of 1 set on accept.
    not_wordgate #(
        .w (W)
    ) u_not_b (
        .a (b),
        .y (w_b_inv)
    );

    assign w_b_sel = (op_sub == OP_SUB) ? w_b_inv : b;

    assign w_a_slice = a_q[idx_q*CHUNK +: CHUNK];
    assign w_b_slice = b_q[idx_q*CHUNK +: CHUNK];

    chunk_adder #(
        .w (CHUNK)
    ) u_slice_add (
        .a    (w_a_slice),
        .b    (w_b_slice),
        .cin  (carry_q),
        .s    (w_sum_slice),
        .cout (w_slice_cout)
    );

    // Full word with the current slice merged in; the final flags need it.
    always_comb begin
        w_result_upd = result_q;
        w_result_upd[idx_q*CHUNK +: CHUNK] = w_sum_slice;
    end

    assign w_last = (idx_q == C_IDX_LAST);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = w_b_sel;
                    carry_d  = op_sub;
                    idx_d    = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    zero_d   = 1'b0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                result_d = w_result_upd;
                carry_d  = w_slice_cout;
                if (w_last) begin
                    state_d = DONE;
                    cout_d  = w_slice_cout;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) &&
                              (w_result_upd[W-1] != a_q[W-1]);
                    zero_d  = (w_result_upd == '0);
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;

endmodule : addsub_seq_64
`default_nettype wire

// File: tb/tb_addsub_seq_64.sv
`default_nettype none
// ============================================================================
// Module      : tb_addsub_seq_64
// Description : Directed self-checking bench for addsub_seq_64.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_seq_64;

    localparam int W   = 64;
    localparam int NCH = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         zero;

    int vecs;
    int errs;

    addsub_seq_64 #(
        .W     (W),
        .CHUNK (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_sub (op_sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf),
        .zero   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vsub;
        logic [W-1:0] er;
        logic         ec;
        logic         ev;
        logic         ez;
    } vec_t;

    // Accepts one operation and watches a bounded window; observations only.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tsub, output logic [W-1:0] r_acc,
                          output logic busy_acc, output int done_at,
                          output int done_cnt, output int busy_drop);
        a      = ta;
        b      = tb_v;
        op_sub = tsub;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        r_acc    = result;
        busy_acc = busy;
        done_at  = -1;
        done_cnt = 0;
        busy_drop = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (!busy && busy_drop < 0) busy_drop = k;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        a = 64'h5;
        b = 64'h3;
        op_sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        vecs++;
        if ({busy, done, cout, ovf, zero} !== 5'b0 || result !== '0) begin
            errs++;
            $display("FAIL reset: busy=%b done=%b res=%h c=%b v=%b z=%b, required all 0",
                     busy, done, result, cout, ovf, zero);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        vecs++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL reset_start_dropped: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_arith();
        vec_t vt [9];
        logic [W-1:0] r_acc;
        logic busy_acc;
        int done_at, done_cnt, busy_drop;
        vt = '{
            '{64'h5, 64'h3, 1'b0, 64'h8, 1'b0, 1'b0, 1'b0},
            '{64'h5, 64'h3, 1'b1, 64'h2, 1'b1, 1'b0, 1'b0},
            '{64'h3, 64'h5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0},
            '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0},
            '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0},
            '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1},
            '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1},
            '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0},
            '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1}
        };
        for (int i = 0; i < 9; i++) begin
            run_op(vt[i].va, vt[i].vb, vt[i].vsub, r_acc, busy_acc, done_at, done_cnt, busy_drop);
            vecs++;
            if (result !== vt[i].er || cout !== vt[i].ec || ovf !== vt[i].ev || zero !== vt[i].ez) begin
                errs++;
                $display("FAIL arith[%0d]: res=%h c=%b v=%b z=%b, required res=%h c=%b v=%b z=%b",
                         i, result, cout, ovf, zero, vt[i].er, vt[i].ec, vt[i].ev, vt[i].ez);
            end
            vecs++;
            if (done_at !== NCH || done_cnt !== 1 || busy_drop !== NCH + 1) begin
                errs++;
                $display("FAIL timing[%0d]: done_at=%0d done_cnt=%0d busy_drop=%0d, required %0d 1 %0d",
                         i, done_at, done_cnt, busy_drop, NCH, NCH + 1);
            end
            vecs++;
            if (r_acc !== '0 || busy_acc !== 1'b1) begin
                errs++;
                $display("FAIL accept[%0d]: res=%h busy=%b, required res=0 busy=1",
                         i, r_acc, busy_acc);
            end
        end
    endtask

    task automatic test_handshake();
        int done_cnt;
        logic [W-1:0] r_acc;
        logic busy_acc;
        int done_at, busy_drop;
        done_cnt = 0;
        a = 64'h5; b = 64'h3; op_sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= NCH + 1; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) done_cnt++;
            if (k == 3 || k == NCH) begin
                a = 64'h100; b = 64'h200; op_sub = 1'b1; start = 1'b1;
            end
        end
        vecs++;
        if (result !== 64'h8 || done_cnt !== 1 || busy !== 1'b0) begin
            errs++;
            $display("FAIL handshake_ignore: res=%h done_cnt=%0d busy=%b, required res=8 done_cnt=1 busy=0",
                     result, done_cnt, busy);
        end
        run_op(64'd10, 64'd20, 1'b0, r_acc, busy_acc, done_at, done_cnt, busy_drop);
        vecs++;
        if (busy_acc !== 1'b1 || result !== 64'd30 || done_at !== NCH) begin
            errs++;
            $display("FAIL handshake_accept: busy=%b res=%h done_at=%0d, required busy=1 res=1e done_at=%0d",
                     busy_acc, result, done_at, NCH);
        end
    endtask

    task automatic test_reset_mid();
        int done_cnt;
        logic [W-1:0] r_acc;
        logic busy_acc;
        int done_at, busy_drop;
        done_cnt = 0;
        a = 64'h7FFF_FFFF_FFFF_FFFF; b = 64'h1; op_sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        vecs++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || {cout, ovf, zero} !== 3'b0) begin
            errs++;
            $display("FAIL reset_mid: busy=%b done=%b res=%h c=%b v=%b z=%b, required all 0",
                     busy, done, result, cout, ovf, zero);
        end
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_cnt++;
        end
        vecs++;
        if (done_cnt !== 0) begin
            errs++;
            $display("FAIL reset_mid_nodone: activity cycles=%0d, required 0", done_cnt);
        end
        run_op(64'h5, 64'h3, 1'b0, r_acc, busy_acc, done_at, done_cnt, busy_drop);
        vecs++;
        if (result !== 64'h8 || done_cnt !== 1 || done_at !== NCH) begin
            errs++;
            $display("FAIL reset_mid_recover: res=%h done_cnt=%0d done_at=%0d, required res=8 1 %0d",
                     result, done_cnt, done_at, NCH);
        end
    endtask

    initial begin
        vecs   = 0;
        errs   = 0;
        rst    = 1'b1;
        start  = 1'b0;
        op_sub = 1'b0;
        a      = '0;
        b      = '0;
        test_reset();
        test_arith();
        test_handshake();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule : tb_addsub_seq_64
`default_nettype wire
